// File: rtl/game_defs_pkg.sv
// Shared tile-map game constants, direction bit indices and
// collision scheduler FSM encodings.
package game_defs;

  localparam int COLS    = 15;
  localparam int ROWS    = 10;
  localparam int TILE_W  = 64;
  localparam int TILE_H  = 64;
  localparam int HERO_W  = 48;
  localparam int HERO_H  = 48;
  localparam int STEP    = 1;
  localparam int N_TILES = COLS * ROWS;
  localparam int CW      = 13;

  localparam int DIR_UP    = 0;
  localparam int DIR_DOWN  = 1;
  localparam int DIR_LEFT  = 2;
  localparam int DIR_RIGHT = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/collision_scheduler_box_overlap.sv
// Half-open axis-aligned box overlap test on signed coordinates.
// One extra internal bit keeps edge sums from overflowing.
module box_overlap #(
  parameter int W = 13
) (
  input  logic signed [W-1:0] ax,
  input  logic signed [W-1:0] ay,
  input  logic signed [W-1:0] aw,
  input  logic signed [W-1:0] ah,
  input  logic signed [W-1:0] bx,
  input  logic signed [W-1:0] by,
  input  logic signed [W-1:0] bw,
  input  logic signed [W-1:0] bh,
  output logic                hit
);

  logic signed [W:0] ax_e, ay_e, aw_e, ah_e;
  logic signed [W:0] bx_e, by_e, bw_e, bh_e;

  assign ax_e = (W+1)'(ax);
  assign ay_e = (W+1)'(ay);
  assign aw_e = (W+1)'(aw);
  assign ah_e = (W+1)'(ah);
  assign bx_e = (W+1)'(bx);
  assign by_e = (W+1)'(by);
  assign bw_e = (W+1)'(bw);
  assign bh_e = (W+1)'(bh);

  assign hit = (ax_e < bx_e + bw_e) && (bx_e < ax_e + aw_e) &&
               (ay_e < by_e + bh_e) && (by_e < ay_e + ah_e);

endmodule

// File: rtl/collision_scheduler.sv
// Frame-synchronous collision scheduler: on each vblank rising edge,
// walks all tiles once and publishes a 4-direction collision vector.
module collision_scheduler
  import game_defs::*;
#(
  parameter int P_COLS   = COLS,
  parameter int P_ROWS   = ROWS,
  parameter int P_TILE_W = TILE_W,
  parameter int P_TILE_H = TILE_H,
  parameter int P_HERO_W = HERO_W,
  parameter int P_HERO_H = HERO_H,
  parameter int P_STEP   = STEP
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       vblnk_in,
  input  logic [P_COLS*P_ROWS-1:0]   map,
  input  logic [11:0]                hero_x_pos,
  input  logic [11:0]                hero_y_pos,
  output logic [3:0]                 collision,
  output logic                       collision_valid,
  output logic                       busy,
  output logic [11:0]                wall_x_pos,
  output logic [11:0]                wall_y_pos
);

  localparam int NT = P_COLS * P_ROWS;
  localparam int RW = $clog2(P_ROWS);
  localparam int KW = $clog2(P_COLS);

  localparam logic signed [CW-1:0] STEP_S = CW'(P_STEP);
  localparam logic signed [CW-1:0] HW_S   = CW'(P_HERO_W);
  localparam logic signed [CW-1:0] HH_S   = CW'(P_HERO_H);
  localparam logic signed [CW-1:0] TW_S   = CW'(P_TILE_W);
  localparam logic signed [CW-1:0] TH_S   = CW'(P_TILE_H);

  localparam logic [13:0] STEP_U = 14'(P_STEP);
  localparam logic [13:0] HW_U   = 14'(P_HERO_W);
  localparam logic [13:0] HH_U   = 14'(P_HERO_H);
  localparam logic [13:0] FW_U   = 14'(P_COLS * P_TILE_W);
  localparam logic [13:0] FH_U   = 14'(P_ROWS * P_TILE_H);

  state_t          state_q, state_d;
  logic            vblnk_q;
  logic [NT-1:0]   map_q, map_d;
  logic [11:0]     hx_q, hx_d, hy_q, hy_d;
  logic [RW-1:0]   r_q, r_d;
  logic [KW-1:0]   c_q, c_d;
  logic [3:0]      acc_q, acc_d;
  logic [3:0]      coll_q, coll_d;
  logic            valid_q, valid_d;

  logic            start, last, wall;
  logic [3:0]      hit, flags, bnd;
  logic signed [CW-1:0] hx_s, hy_s, tile_x, tile_y;
  logic signed [CW-1:0] up_y, dn_y, lf_x, rt_x;
  logic [13:0]     hx_u, hy_u;

  assign start  = vblnk_in & ~vblnk_q;
  assign last   = (r_q == RW'(P_ROWS-1)) && (c_q == KW'(P_COLS-1));
  // map_q shifts left each scan cycle, so the MSB is always tile (r,c)
  assign wall   = map_q[NT-1];

  assign hx_s   = signed'({1'b0, hx_q});
  assign hy_s   = signed'({1'b0, hy_q});
  assign tile_x = CW'(c_q * P_TILE_W);
  assign tile_y = CW'(r_q * P_TILE_H);
  assign up_y   = hy_s - STEP_S;
  assign dn_y   = hy_s + STEP_S;
  assign lf_x   = hx_s - STEP_S;
  assign rt_x   = hx_s + STEP_S;

  box_overlap #(.W(CW)) u_up (
    .ax(hx_s), .ay(up_y), .aw(HW_S), .ah(HH_S),
    .bx(tile_x), .by(tile_y), .bw(TW_S), .bh(TH_S),
    .hit(hit[DIR_UP])
  );

  box_overlap #(.W(CW)) u_dn (
    .ax(hx_s), .ay(dn_y), .aw(HW_S), .ah(HH_S),
    .bx(tile_x), .by(tile_y), .bw(TW_S), .bh(TH_S),
    .hit(hit[DIR_DOWN])
  );

  box_overlap #(.W(CW)) u_lf (
    .ax(lf_x), .ay(hy_s), .aw(HW_S), .ah(HH_S),
    .bx(tile_x), .by(tile_y), .bw(TW_S), .bh(TH_S),
    .hit(hit[DIR_LEFT])
  );

  box_overlap #(.W(CW)) u_rt (
    .ax(rt_x), .ay(hy_s), .aw(HW_S), .ah(HH_S),
    .bx(tile_x), .by(tile_y), .bw(TW_S), .bh(TH_S),
    .hit(hit[DIR_RIGHT])
  );

  assign flags = hit & {4{wall}};
  assign hx_u  = {2'b00, hx_q};
  assign hy_u  = {2'b00, hy_q};

  always_comb begin
    bnd            = 4'b0000;
    bnd[DIR_UP]    = hy_u < STEP_U;
    bnd[DIR_LEFT]  = hx_u < STEP_U;
    bnd[DIR_DOWN]  = (hy_u + HH_U + STEP_U) > FH_U;
    bnd[DIR_RIGHT] = (hx_u + HW_U + STEP_U) > FW_U;
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (start) state_d = ST_SCAN;
      ST_SCAN: if (last)  state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy            = (state_q == ST_SCAN);
    collision       = coll_q;
    collision_valid = valid_q;
    wall_x_pos      = 12'(c_q * P_TILE_W);
    wall_y_pos      = 12'(r_q * P_TILE_H);
  end

  always_comb begin
    map_d   = map_q;
    hx_d    = hx_q;
    hy_d    = hy_q;
    r_d     = r_q;
    c_d     = c_q;
    acc_d   = acc_q;
    coll_d  = coll_q;
    valid_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          map_d = map;
          hx_d  = hero_x_pos;
          hy_d  = hero_y_pos;
          r_d   = '0;
          c_d   = '0;
          acc_d = 4'b0000;
        end
      end
      ST_SCAN: begin
        acc_d = acc_q | flags;
        map_d = map_q << 1;
        if (last) begin
          coll_d  = acc_q | flags | bnd;
          valid_d = 1'b1;
        end else if (c_q == KW'(P_COLS-1)) begin
          c_d = '0;
          r_d = r_q + 1'b1;
        end else begin
          c_d = c_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vblnk_q <= 1'b0;
      map_q   <= '0;
      hx_q    <= '0;
      hy_q    <= '0;
      r_q     <= '0;
      c_q     <= '0;
      acc_q   <= 4'b0000;
      coll_q  <= 4'b0000;
      valid_q <= 1'b0;
    end else begin
      vblnk_q <= vblnk_in;
      map_q   <= map_d;
      hx_q    <= hx_d;
      hy_q    <= hy_d;
      r_q     <= r_d;
      c_q     <= c_d;
      acc_q   <= acc_d;
      coll_q  <= coll_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: doc/collision_scheduler.md
# collision_scheduler

Frame-synchronous collision scheduler for the tile-map game field. Once per frame, on the rising edge of vertical blanking, it snapshots the 150-bit wall map and the hero position. It then walks all 15×10 tiles, one tile per clock, and tests each wall tile against the hero box shifted one step in each direction. It publishes a registered 4-bit collision vector that the hero controller consumes before its next move.

## Interface
- `COLS`, 15: tiles per row
- `ROWS`, 10: tile rows
- `TILE_W`, 64: tile width, pixels
- `TILE_H`, 64: tile height, pixels
- `HERO_W`, 48: hero box width, pixels
- `HERO_H`, 48: hero box height, pixels
- `STEP`, 1: probe distance, pixels
- `clk`  in  1: pixel clock; the only clock
- `rst`  in  1: synchronous, active-high reset
- `vblnk_in`  in  1: vertical blank from the timing generator
- `map`  in  150: wall map; 1 = wall; `map[149]` = row 0 col 0; index = `(ROWS-1-r)*COLS + (COLS-1-c)`
- `hero_x_pos`  in  12: hero left edge, pixels
- `hero_y_pos`  in  12: hero top edge, pixels
- `collision`  out  4: bit0 up, bit1 down, bit2 left, bit3 right
- `collision_valid`  out  1: one-cycle pulse when `collision` updates
- `busy`  out  1: scan in progress
- `wall_x_pos`  out  12: pixel x of the tile under test (`c*TILE_W`)
- `wall_y_pos`  out  12: pixel y of the tile under test (`r*TILE_H`)

## Operation
- FSM states: IDLE, SCAN, DONE.
- `vblnk_d` registers `vblnk_in`. A start event is a cycle with `vblnk_in & ~vblnk_d`.
- **IDLE, on start:**
  - latch `map`, `hero_x_pos`, `hero_y_pos`;
  - set r = c = 0 and acc = 0;
  - go to SCAN.
- **SCAN, each cycle:** evaluate tile (r,c). If it is a wall, OR four overlap flags into acc.
  - Up: hero box at y−STEP.
  - Down: hero box at y+STEP.
  - Left: hero box at x−STEP.
  - Right: hero box at x+STEP.
  - Advance c. At c = COLS−1, wrap c to 0 and increment r.
  - After (ROWS−1, COLS−1), go to DONE.
- **Overlap rule:** boxes A and B overlap iff `ax < bx+bw && bx < ax+aw` and `ay < by+bh && by < ay+ah`. Intervals are half-open, so touching edges do not overlap.
- **DONE, one cycle:**
  - `collision` <= acc | boundary, where boundary is:
    - up if y < STEP;
    - left if x < STEP;
    - down if y + HERO_H + STEP > ROWS*TILE_H;
    - right if x + HERO_W + STEP > COLS*TILE_W.
  - pulse `collision_valid`;
  - return to IDLE.
- **Arithmetic:** 13-bit signed intermediates, so that y−STEP at y = 0 cannot wrap. A negative shifted edge never matches a tile; the boundary term covers it.
- **Start during SCAN or DONE:** ignored. No re-trigger and no queueing.
- **Input changes during a scan:** ignored. `map` and hero position are snapshotted.
- **Between scans:** `collision` holds its last value.
- **Reset (including mid-scan):** IDLE, r = c = 0, acc = 0. Outputs per Timing.

## Timing
- Reset values: `collision` = 0, `collision_valid` = 0, `busy` = 0, `wall_x_pos` = 0, `wall_y_pos` = 0.
- With start detected in cycle N:
  - SCAN occupies cycles N+1 … N+150, and `busy` = 1 for exactly those cycles.
  - `collision` and `collision_valid` are registered and first visible in cycle N+151.
- `wall_x_pos` / `wall_y_pos` are combinational from r/c, valid only while `busy`, and hold the last tile afterwards.
- The scan fits within any vertical blank longer than 151 clocks.

## Structure
- **Shared header (`game_defs`):**
  - constants COLS, ROWS, TILE_W, TILE_H;
  - direction bit indices DIR_UP = 0, DIR_DOWN = 1, DIR_LEFT = 2, DIR_RIGHT = 3;
  - FSM state encodings.
- **Sub-module `box_overlap`:** combinational, parameterised widths, two boxes in, one bit out. Four instances, one per direction.
- Everything else is in `collision_scheduler`: edge detector, FSM, r/c counters, snapshot registers, accumulator.

## Test plan
- Empty map, hero (0,0), one vblank -> at N+151 `collision` = 4'b0101 with a one-cycle `collision_valid`; `busy` high for exactly 150 cycles.
- Wall at r5 c2 (x 128–191, y 320–383), hero (80,320) -> 4'b1000. The same wall with hero (64,320) -> 4'b0000.
- Same wall, hero (192,320) -> 4'b0100. Hero (128,384) -> 4'b0001.
- Empty map, hero (912,592) -> 4'b1010.
- Reset asserted at cycle N+40 of a scan -> next cycle `busy` = 0 and `collision` = 0, with no `collision_valid`. The next vblank completes a normal scan.
- Second vblank edge during SCAN, plus map and hero changes mid-scan -> no restart. Result reflects the snapshot, and exactly one valid pulse is produced.
